vx_ibuffer_multi: RTL
=====================

VX_IBUFFER_MULTI -- requirements
Module: VX_ibuffer_multi

Interface
REQ-001 SHALL have parameter WARP_CNT, default `NUM_WARPS: total warps.
REQ-002 SHALL have parameter ISSUE_CNT, default `MIN(WARP_CNT,4): number of issue slices; WARP_CNT divisible by ISSUE_CNT.
REQ-003 SHALL have parameter DEPTH, default 2*(WARP_CNT/ISSUE_CNT): entries per slice; power of two, >=2.
REQ-004 SHALL have parameter DATAW, default 64: instruction payload width, excluding warp-in-slice index.
REQ-005 SHALL have parameter AF_MARGIN, default 1: almost-full distance from full; 0 < AF_MARGIN < DEPTH.
REQ-006 SHALL have the following ports (WIDW = LOG2UP(WARP_CNT), WISW = LOG2UP(WARP_CNT/ISSUE_CNT), CNTW = LOG2UP(DEPTH+1)):
- clk  in  1  clock; reset  in  1  asynchronous active-high reset.
- decode_valid  in  1  decoded instruction valid.
- decode_wid  in  WIDW  source warp id.
- decode_data  in  DATAW  instruction payload.
- decode_ready  out  1  accepted by selected slice.
- flush  in  ISSUE_CNT  per-slice discard of all entries.
- out_valid  out  ISSUE_CNT  per-slice head valid.
- out_data  out  ISSUE_CNT x (WISW+DATAW)  per-slice head, {wis, payload}.
- out_ready  in  ISSUE_CNT  per-slice consumer ready.
- ibuf_pop  out  ISSUE_CNT  per-slice dequeue strobe.
- count  out  ISSUE_CNT x CNTW  per-slice occupancy.
- almost_full  out  ISSUE_CNT  per-slice occupancy >= DEPTH-AF_MARGIN.

Function
REQ-007 SHALL steer each instruction to slice isw = decode_wid mod ISSUE_CNT, storing wis = decode_wid / ISSUE_CNT alongside the payload.
REQ-008 SHALL assert decode_ready = (count[isw] < DEPTH) and not flush[isw]; combinational, no dependence on out_ready.
REQ-009 SHALL enqueue into slice isw exactly when decode_valid and decode_ready; other slices are unaffected.
REQ-010 SHALL implement each slice as a circular FIFO, write pointer and read pointer of LOG2(DEPTH) bits wrapping modulo DEPTH.
REQ-011 SHALL assert out_valid[i] = (count[i] != 0); out_data[i] is the oldest entry, registered, stable while out_valid[i] and not out_ready[i].
REQ-012 SHALL give enqueue-to-out_valid latency of exactly 1 cycle into an empty slice; no combinational input-to-output path.
REQ-013 SHALL assert ibuf_pop[i] = out_valid[i] and out_ready[i] and not flush[i]; dequeue occurs on that strobe.
REQ-014 SHALL leave count[i] unchanged on simultaneous push and pop, +1 on push only, -1 on pop only.
REQ-015 SHALL, on flush[i], set count[i]=0 and both pointers to 0 next cycle, drop any same-cycle push/pop to slice i, and leave other slices unaffected.
REQ-016 SHALL hold almost_full[i] = (count[i] >= DEPTH-AF_MARGIN), combinational from count.
REQ-017 SHALL never overflow or underflow; full slice with out_ready high accepts a push only the cycle after the pop.
REQ-018 SHALL preserve per-slice FIFO order; no ordering between slices is implied.

Reset
REQ-019 SHALL, while reset is high, drive count=0, pointers=0, out_valid=0, ibuf_pop=0, almost_full=0; decode_ready is 0 during reset.
REQ-020 SHALL discard all buffered entries on reset asserted mid-operation; storage contents need not be cleared.

Structure
REQ-021 SHALL place ISSUE_CNT default, WID-to-ISW/WIS helpers and the {wis,payload} entry typedef in the shared core package.
REQ-022 SHALL instantiate one sub-module VX_ibuf_slice (FIFO + count + flush) per slice via generate.

Verification
REQ-023 SHALL cover: WARP_CNT=8, ISSUE_CNT=4, push wid=5 -> slice 1, out_data wis=1, out_valid[1] one cycle later, others 0.
REQ-024 SHALL cover: DEPTH=4, out_ready=0, push 4 instrs wid=0 -> count[0]=4, decode_ready=0 for wid=0/4, almost_full[0]=1 from count 3.
REQ-025 SHALL cover: full slice, out_ready=1 and decode_valid held -> pop cycle count 3, next cycle push accepted, count 4, order 1..5 preserved.
REQ-026 SHALL cover: count[2]=3, flush[2] with simultaneous push to slice 2 and pop -> ibuf_pop[2]=0, count[2]=0 next cycle, slice 0 count unchanged.
REQ-027 SHALL cover: 6 pushes through DEPTH=4 with interleaved pops -> pointer wrap, data order intact, count never >4.
REQ-028 SHALL cover: reset asserted asynchronously with count=2 -> outputs zero immediately, count=0 after release.

Source files
------------

// File: rtl/vx_ibuffer_multi_pkg.sv
// Shared core definitions for the multi-slice instruction buffer.
// Provides default sizing, warp-id to slice/index helpers and the
// {wis, payload} entry layout used by the default configuration.
package vx_ibuffer_multi_pkg;

  localparam int unsigned NUM_WARPS = 8;

  // Bits needed to index x items; never less than one bit.
  function automatic int unsigned log2up(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  localparam int unsigned ISSUE_CNT_DEF = min_u(NUM_WARPS, 4);
  localparam int unsigned DATAW_DEF     = 64;
  localparam int unsigned WISW_DEF      = log2up(NUM_WARPS / ISSUE_CNT_DEF);

  // Buffered entry for the default configuration: warp-in-slice index above payload.
  typedef struct packed {
    logic [WISW_DEF-1:0]  wis;
    logic [DATAW_DEF-1:0] payload;
  } ibuf_entry_t;

  // Slice that owns a warp: warps are interleaved across slices.
  function automatic int unsigned wid_to_isw(input int unsigned wid, input int unsigned issue_cnt);
    return wid % issue_cnt;
  endfunction

  // Position of a warp inside its slice.
  function automatic int unsigned wid_to_wis(input int unsigned wid, input int unsigned issue_cnt);
    return wid / issue_cnt;
  endfunction

endpackage

// File: rtl/vx_ibuffer_multi_slice.sv
// One instruction-buffer slice: circular FIFO with occupancy count and flush.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push_valid        instruction presented to this slice
//   din               {wis, payload} entry to store
//   flush             discard all entries (next cycle empty)
//   ready             slice can accept a push this cycle
//   out_valid/out_data head entry (registered storage)
//   out_ready         consumer ready
//   ibuf_pop          dequeue strobe
//   count             occupancy
//   almost_full       occupancy >= DEPTH-AF_MARGIN
module vx_ibuffer_multi_slice
  import vx_ibuffer_multi_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ENTW      = 65,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned CNTW      = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_valid,
  input  logic [ENTW-1:0] din,
  input  logic            flush,
  output logic            ready,
  output logic            out_valid,
  output logic [ENTW-1:0] out_data,
  input  logic            out_ready,
  output logic            ibuf_pop,
  output logic [CNTW-1:0] count,
  output logic            almost_full
);

  localparam int unsigned PW = log2up(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [ENTW-1:0] mem_q [DEPTH];
  logic            push;
  logic            pop;

  // A full slice does not take a push even when it pops in the same cycle.
  assign ready       = !reset && (count_q < CNTW'(DEPTH)) && !flush;
  assign push        = push_valid && ready;
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready && !flush;
  assign ibuf_pop    = pop;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CNTW'(DEPTH - AF_MARGIN));

  // Pointer and occupancy update; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CNTW'(1);
      else if (!push && pop) count_d = count_q - CNTW'(1);
    end
  end

  // Control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vx_ibuffer_multi.sv
// Multi-slice instruction buffer: decoded instructions are steered to
// slice (wid mod ISSUE_CNT) and stored with their warp-in-slice index.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   decode_valid/wid/data/ready   decode-side handshake
//   flush[ISSUE_CNT]              per-slice discard
//   out_valid/out_data/out_ready  per-slice head handshake, data {wis, payload}
//   ibuf_pop[ISSUE_CNT]           per-slice dequeue strobe
//   count[ISSUE_CNT*CNTW]         per-slice occupancy
//   almost_full[ISSUE_CNT]        per-slice almost-full flag
module vx_ibuffer_multi
  import vx_ibuffer_multi_pkg::*;
#(
  parameter int unsigned WARP_CNT  = NUM_WARPS,
  parameter int unsigned ISSUE_CNT = min_u(WARP_CNT, 4),
  parameter int unsigned DEPTH     = 2 * (WARP_CNT / ISSUE_CNT),
  parameter int unsigned DATAW     = 64,
  parameter int unsigned AF_MARGIN = 1,
  localparam int unsigned WIDW     = log2up(WARP_CNT),
  localparam int unsigned WISW     = log2up(WARP_CNT / ISSUE_CNT),
  localparam int unsigned CNTW     = log2up(DEPTH + 1),
  localparam int unsigned ENTW     = WISW + DATAW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      decode_valid,
  input  logic [WIDW-1:0]           decode_wid,
  input  logic [DATAW-1:0]          decode_data,
  output logic                      decode_ready,
  input  logic [ISSUE_CNT-1:0]      flush,
  output logic [ISSUE_CNT-1:0]      out_valid,
  output logic [ISSUE_CNT*ENTW-1:0] out_data,
  input  logic [ISSUE_CNT-1:0]      out_ready,
  output logic [ISSUE_CNT-1:0]      ibuf_pop,
  output logic [ISSUE_CNT*CNTW-1:0] count,
  output logic [ISSUE_CNT-1:0]      almost_full
);

  localparam int unsigned ISWW = log2up(ISSUE_CNT);

  logic [ISWW-1:0]      isw;
  logic [WISW-1:0]      wis;
  logic [ISSUE_CNT-1:0] sel;
  logic [ISSUE_CNT-1:0] slice_ready;

  assign isw = ISWW'(wid_to_isw(32'(decode_wid), ISSUE_CNT));
  assign wis = WISW'(wid_to_wis(32'(decode_wid), ISSUE_CNT));

  // Ready reflects only the slice the current warp maps to.
  assign decode_ready = |(sel & slice_ready);

  for (genvar i = 0; i < ISSUE_CNT; i++) begin : g_slice
    assign sel[i] = (isw == ISWW'(i));

    vx_ibuffer_multi_slice #(
      .DEPTH     (DEPTH),
      .ENTW      (ENTW),
      .AF_MARGIN (AF_MARGIN),
      .CNTW      (CNTW)
    ) u_slice (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (decode_valid && sel[i]),
      .din         ({wis, decode_data}),
      .flush       (flush[i]),
      .ready       (slice_ready[i]),
      .out_valid   (out_valid[i]),
      .out_data    (out_data[i*ENTW +: ENTW]),
      .out_ready   (out_ready[i]),
      .ibuf_pop    (ibuf_pop[i]),
      .count       (count[i*CNTW +: CNTW]),
      .almost_full (almost_full[i])
    );
  end

endmodule
